clk_meas: RTL and testbench
===========================

# clk_meas

Synthesizable clock characterizer that measures an asynchronous input clock against the system clock. On request it reports phase offset from a reference pulse, high time, low time and period of `sig_in`, all in system-clock cycles. It is the receive-side counterpart of the testbench clock generators: it recovers the freq/duty/phase parameters they were built from. It sits next to the design under test as an on-chip or bench-side monitor.

## Interface
- `CNT_W`, 16: width of the phase, high and low counters.
- `SYNC_STAGES`, 2: synchronizer flops on `sig_in`; minimum 2.

- `clk` input 1: system clock; all logic on its rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `sig_in` input 1: clock under measurement, asynchronous to `clk`.
- `start` input 1: one-cycle request to begin a measurement.
- `ref_pulse` input 1: one-cycle phase-zero marker, synchronous to `clk`.
- `busy` output 1: a measurement is in progress.
- `valid` output 1: one-cycle pulse when results update.
- `err` output 1: last result aborted on counter saturation; valid when `valid`=1, held until the next `valid`.
- `phase_cyc` output CNT_W: cycles from `ref_pulse` to detected rising edge.
- `ton_cyc` output CNT_W: cycles from detected rise to detected fall.
- `toff_cyc` output CNT_W: cycles from detected fall to the next detected rise.
- `period_cyc` output CNT_W+1: `ton_cyc + toff_cyc`, zero-extended, no overflow.

## Operation
- `sig_in` passes through SYNC_STAGES flops, then one history flop. rise = sync & ~hist, fall = ~sync & hist. No edge is ever lost or double-counted.
- FSM states: IDLE, ARM, PHASE, HIGH, LOW, DONE.
  - IDLE: `busy`=0. `start` moves to ARM. Edges and `ref_pulse` are ignored.
  - ARM: wait for `ref_pulse`. A `ref_pulse` in the same cycle as the accepting `start` is ignored. Rises seen before `ref_pulse` are ignored.
  - PHASE: count until rise, then latch `phase_cyc` and go to HIGH.
  - HIGH: count until fall, then latch `ton_cyc` and go to LOW.
  - LOW: count until rise, then latch `toff_cyc` and go to DONE.
  - DONE: pulse `valid` for 1 cycle, then return to IDLE.
- Count definition: each count is the difference in clk-cycle index between the two marking events. Phase is the `ref_pulse` cycle to the rise-detect cycle. High is the rise-detect cycle to the fall-detect cycle. Low is the fall-detect cycle to the next rise-detect cycle.
- `ref_pulse` and rise in the same cycle while in ARM: `phase_cyc`=0, and the FSM goes straight to HIGH.
- Saturation: if the active counter reaches 2^CNT_W−1 before its terminating event, go to DONE with `err`=1. Counts not yet measured are reported as 0. The saturating count is reported as 2^CNT_W−1.
- `start` while `busy`=1 is ignored. Extra `ref_pulse` pulses after ARM are ignored.
- Result outputs hold their values between `valid` pulses. All result outputs update in the same cycle that `valid` rises.

## Timing
- Reset values: `busy`=0, `valid`=0, `err`=0, all counts 0, synchronizer and history flops 0, FSM in IDLE.
- `rst` mid-measurement: all outputs return to reset values immediately, and no `valid` is produced.
- Detection latency: a `sig_in` level first sampled at clk edge n produces rise/fall in the cycle after edge n+SYNC_STAGES. The latency is identical for rise and fall, so ton and toff are uncompensated yet exact to ±1 cycle.
- `phase_cyc` includes the detection latency, which is SYNC_STAGES+1 cycles. Raw values are reported; no compensation is applied.
- `busy` rises the cycle after `start` is accepted and falls in the cycle `valid` is high.
- Minimum measurable high or low time is 1 clk cycle; narrower pulses may be missed.

## Configuration
- `CLK_MEAS_PHASE_EN` defined: ARM and PHASE states exist, and `ref_pulse` is used as described.
- `CLK_MEAS_PHASE_EN` not defined:
  - `start` moves IDLE directly to a wait-for-rise state, and the first rise enters HIGH.
  - `ref_pulse` is ignored.
  - `phase_cyc` is tied to 0.
  - Saturation while waiting for the first rise sets `err`.

## Test plan
Bench setup: `clk` 100 MHz (10 ns), SYNC_STAGES=2.
- `sig_in` at 10 MHz, 50 % duty, phase enabled, `ref_pulse` then `start` -> `ton_cyc`=5, `toff_cyc`=5, `period_cyc`=10, `err`=0.
- `sig_in` at 10 MHz, 30 % duty; `ref_pulse` issued 4 cycles before the clk edge that first samples the `sig_in` rise -> `phase_cyc`=7, `ton_cyc`=3, `toff_cyc`=7, `period_cyc`=10.
- CNT_W=8, `sig_in` held low, `ref_pulse` given -> after 255 cycles, `valid`=1 and `err`=1 with `phase_cyc`=255 and `ton_cyc`=`toff_cyc`=0.
- `ref_pulse` coincident with the rise-detect cycle in ARM -> `phase_cyc`=0, and ton/toff are still correct.
- Second `start` while `busy`=1 -> ignored, producing exactly one `valid`. `rst` asserted in HIGH -> `busy`=0, counts 0, no `valid`.
- Built without `CLK_MEAS_PHASE_EN`, 10 MHz 50 % duty, no `ref_pulse` -> `valid` with `phase_cyc`=0, `ton_cyc`=5, `toff_cyc`=5.

Source files
------------

// File: rtl/clk_meas.sv
// clk_meas: measures phase (from ref_pulse), high time, low time and period
// of an asynchronous clock sig_in, in system-clock cycles.
// Optional feature macro: CLK_MEAS_PHASE_EN. When it is defined, the block
// arms on start, waits for ref_pulse and measures phase. Otherwise start goes
// straight to waiting for the first rise, and phase_cyc is tied to 0.
module clk_meas #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2   // minimum 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  input  logic             ref_pulse,
  output logic             busy,
  output logic             valid,
  output logic             err,
  output logic [CNT_W-1:0] phase_cyc,
  output logic [CNT_W-1:0] ton_cyc,
  output logic [CNT_W-1:0] toff_cyc,
  output logic [CNT_W:0]   period_cyc
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

`ifdef CLK_MEAS_PHASE_EN
  typedef enum logic [2:0] {IDLE, ARM, PHASE, HIGH, LOW, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, WAIT_RISE, HIGH, LOW, DONE} state_t;
`endif

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        ton_r;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    hist_q;
  logic                    rise;
  logic                    fall;

  logic                    fin;
  logic                    fin_err;
  logic [CNT_W-1:0]        fin_ton;
  logic [CNT_W-1:0]        fin_toff;

`ifdef CLK_MEAS_PHASE_EN
  logic [CNT_W-1:0]        phase_r;
  logic [CNT_W-1:0]        fin_phase;
`else
  logic                    unused_ref;
  assign unused_ref = ref_pulse;
  assign phase_cyc  = '0;
`endif

  // Synchronize sig_in, keep one history bit, and register the edge pulses so
  // rise/fall appear in the cycle after the sampling edge + SYNC_STAGES.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      hist_q <= sync_q[SYNC_STAGES-1];
      rise   <= sync_q[SYNC_STAGES-1] & ~hist_q;
      fall   <= ~sync_q[SYNC_STAGES-1] & hist_q;
    end
  end

  // Decide whether this cycle ends the measurement, normally or on saturation,
  // and what the published results must be.
  always_comb begin
    fin      = 1'b0;
    fin_err  = 1'b0;
    fin_ton  = ton_r;
    fin_toff = '0;
`ifdef CLK_MEAS_PHASE_EN
    fin_phase = phase_r;
`endif
    case (state)
`ifdef CLK_MEAS_PHASE_EN
      PHASE: begin
        if (!rise && cnt == CNT_MAX) begin
          fin       = 1'b1;
          fin_err   = 1'b1;
          fin_phase = CNT_MAX;
          fin_ton   = '0;
        end
      end
`else
      WAIT_RISE: begin
        if (!rise && cnt == CNT_MAX) begin
          fin     = 1'b1;
          fin_err = 1'b1;
          fin_ton = '0;
        end
      end
`endif
      HIGH: begin
        if (!fall && cnt == CNT_MAX) begin
          fin     = 1'b1;
          fin_err = 1'b1;
          fin_ton = CNT_MAX;
        end
      end
      LOW: begin
        if (rise) begin
          fin      = 1'b1;
          fin_toff = cnt;
        end else if (cnt == CNT_MAX) begin
          fin      = 1'b1;
          fin_err  = 1'b1;
          fin_toff = CNT_MAX;
        end
      end
      default: ;
    endcase
  end

  // Measurement sequencer: counts cycles between marking events, drives busy/valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      ton_r <= '0;
      busy  <= 1'b0;
      valid <= 1'b0;
`ifdef CLK_MEAS_PHASE_EN
      phase_r <= '0;
`endif
    end else begin
      valid <= 1'b0;
      if (fin) begin
        state <= DONE;
        valid <= 1'b1;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              busy <= 1'b1;
              cnt  <= CNT_ONE;
`ifdef CLK_MEAS_PHASE_EN
              state <= ARM;
`else
              state <= WAIT_RISE;
`endif
            end
          end
`ifdef CLK_MEAS_PHASE_EN
          ARM: begin
            if (ref_pulse) begin
              cnt <= CNT_ONE;
              if (rise) begin
                phase_r <= '0;
                state   <= HIGH;
              end else begin
                state <= PHASE;
              end
            end
          end
          PHASE: begin
            if (rise) begin
              phase_r <= cnt;
              cnt     <= CNT_ONE;
              state   <= HIGH;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
`else
          WAIT_RISE: begin
            if (rise) begin
              cnt   <= CNT_ONE;
              state <= HIGH;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
`endif
          HIGH: begin
            if (fall) begin
              ton_r <= cnt;
              cnt   <= CNT_ONE;
              state <= LOW;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          LOW:     cnt   <= cnt + CNT_ONE;
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Publish all results together in the cycle valid goes high; hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err        <= 1'b0;
      ton_cyc    <= '0;
      toff_cyc   <= '0;
      period_cyc <= '0;
`ifdef CLK_MEAS_PHASE_EN
      phase_cyc  <= '0;
`endif
    end else if (fin) begin
      err        <= fin_err;
      ton_cyc    <= fin_ton;
      toff_cyc   <= fin_toff;
      period_cyc <= {1'b0, fin_ton} + {1'b0, fin_toff};
`ifdef CLK_MEAS_PHASE_EN
      phase_cyc  <= fin_phase;
`endif
    end
  end

endmodule

// File: tb/tb_clk_meas.sv
// tb_clk_meas: directed bench for clk_meas with an event-timestamp model.
// Honours CLK_MEAS_PHASE_EN the same way the design does.
module tb_clk_meas;

  localparam int CNT_W       = 8;
  localparam int SYNC_STAGES = 2;
  localparam int MAX         = (1 << CNT_W) - 1;
`ifdef CLK_MEAS_PHASE_EN
  localparam bit PHASE_EN = 1'b1;
`else
  localparam bit PHASE_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             sig_in = 1'b0;
  logic             start = 1'b0;
  logic             ref_pulse = 1'b0;
  logic             busy, valid, err;
  logic [CNT_W-1:0] phase_cyc, ton_cyc, toff_cyc;
  logic [CNT_W:0]   period_cyc;

  int checks = 0;
  int passed = 0;

  // Generator for sig_in, advanced one step per clk cycle by the driver.
  int gen_per  = 10;
  int gen_high = 5;
  int gen_ph   = 0;
  bit gen_on   = 1'b0;

  // Model state: timestamps (clk-edge indices) of the marking events.
  int       k       = 0;
  logic [7:0] hq    = '0;
  bit       active  = 1'b0;
  bit       cool    = 1'b0;
  int       t_start = -1, t_ref = -1, t_r1 = -1, t_f1 = -1;
  bit       e_busy = 1'b0, e_valid = 1'b0, e_err = 1'b0;
  int       e_phase = 0, e_ton = 0, e_toff = 0;

  clk_meas #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst(rst), .sig_in(sig_in), .start(start), .ref_pulse(ref_pulse),
    .busy(busy), .valid(valid), .err(err), .phase_cyc(phase_cyc),
    .ton_cyc(ton_cyc), .toff_cyc(toff_cyc), .period_cyc(period_cyc)
  );

  // 100 MHz system clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual == expected) passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
  endtask

  // One clk cycle of stimulus, applied 1 ns after the rising edge.
  task automatic applyStimulus(input logic s, input logic r);
    @(posedge clk);
    #1;
    start     = s;
    ref_pulse = r;
    if (gen_on) begin
      sig_in = (gen_ph < gen_high);
      gen_ph = (gen_ph + 1 >= gen_per) ? 0 : gen_ph + 1;
    end else begin
      sig_in = 1'b0;
    end
  endtask

  task automatic waitValid(input int limit, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      applyStimulus(1'b0, 1'b0);
      if (valid === 1'b1) seen = 1'b1;
    end
    if (!seen) checkOutput({name, "_timeout"}, 0, 1);
  endtask

  task automatic modelFinish(input bit er, input int ph, input int tn, input int tf);
    active  = 1'b0;
    cool    = 1'b1;
    e_valid = 1'b1;
    e_busy  = 1'b0;
    e_err   = er;
    e_phase = ph;
    e_ton   = tn;
    e_toff  = tf;
  endtask

  // Model: an edge on sig_in first sampled at edge n is seen at edge n+SYNC_STAGES+1;
  // each result is the difference of the edge indices of its two marking events.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hq = '0; active = 1'b0; cool = 1'b0;
      e_busy = 1'b0; e_valid = 1'b0; e_err = 1'b0;
      e_phase = 0; e_ton = 0; e_toff = 0;
      t_start = -1; t_ref = -1; t_r1 = -1; t_f1 = -1;
    end else begin : step
      bit rise_m, fall_m, was_cool;
      int mark, ph;
      k++;
      hq = {hq[6:0], sig_in};
      rise_m = hq[SYNC_STAGES+1] & ~hq[SYNC_STAGES+2];
      fall_m = ~hq[SYNC_STAGES+1] & hq[SYNC_STAGES+2];
      e_valid  = 1'b0;
      was_cool = cool;
      cool     = 1'b0;
      ph = (PHASE_EN && t_r1 >= 0) ? t_r1 - t_ref : 0;
      if (!active) begin
        if (start && !was_cool) begin
          active = 1'b1; e_busy = 1'b1; t_start = k;
          t_ref = -1; t_r1 = -1; t_f1 = -1;
        end
      end else if (PHASE_EN && t_ref < 0) begin
        if (ref_pulse) begin
          t_ref = k;
          if (rise_m) t_r1 = k;
        end
      end else if (t_r1 < 0) begin
        mark = PHASE_EN ? t_ref : t_start;
        if (rise_m) t_r1 = k;
        else if (k - mark >= MAX) modelFinish(1'b1, PHASE_EN ? MAX : 0, 0, 0);
      end else if (t_f1 < 0) begin
        if (fall_m) t_f1 = k;
        else if (k - t_r1 >= MAX) modelFinish(1'b1, ph, MAX, 0);
      end else begin
        if (rise_m) modelFinish(1'b0, ph, t_f1 - t_r1, k - t_f1);
        else if (k - t_f1 >= MAX) modelFinish(1'b1, ph, t_f1 - t_r1, MAX);
      end
    end
  end

  // Compare every cycle, midway between rising edges.
  always @(negedge clk) begin
    checkOutput("busy", busy, e_busy);
    checkOutput("valid", valid, e_valid);
    checkOutput("err", err, e_err);
    checkOutput("phase_cyc", phase_cyc, e_phase);
    checkOutput("ton_cyc", ton_cyc, e_ton);
    checkOutput("toff_cyc", toff_cyc, e_toff);
    checkOutput("period_cyc", period_cyc, e_ton + e_toff);
  end

  initial begin
    int nvalid;
    bit reached;
    #1 rst = 1'b1;
    repeat (3) applyStimulus(1'b0, 1'b0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_valid", valid, 0);
    checkOutput("reset_err", err, 0);
    checkOutput("reset_ton", ton_cyc, 0);
    checkOutput("reset_period", period_cyc, 0);
    rst = 1'b0;

    // 10 MHz, 50 % duty.
    gen_on = 1'b1; gen_per = 10; gen_high = 5; gen_ph = 0;
    repeat (20) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
`ifdef CLK_MEAS_PHASE_EN
    repeat (3) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
`endif
    waitValid(60, "duty50");
    checkOutput("duty50_ton", ton_cyc, 5);
    checkOutput("duty50_toff", toff_cyc, 5);
    checkOutput("duty50_period", period_cyc, 10);
    checkOutput("duty50_err", err, 0);

`ifdef CLK_MEAS_PHASE_EN
    // 30 % duty with ref_pulse 4 cycles before the edge that first samples the rise.
    gen_on = 1'b0;
    repeat (10) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    repeat (2) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    repeat (3) applyStimulus(1'b0, 1'b0);
    gen_on = 1'b1; gen_per = 10; gen_high = 3; gen_ph = 0;
    waitValid(60, "phase7");
    checkOutput("phase7_phase", phase_cyc, 7);
    checkOutput("phase7_ton", ton_cyc, 3);
    checkOutput("phase7_toff", toff_cyc, 7);
    checkOutput("phase7_period", period_cyc, 10);

    // ref_pulse coincident with the rise-detect cycle while armed.
    gen_on = 1'b0;
    repeat (10) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    repeat (2) applyStimulus(1'b0, 1'b0);
    gen_on = 1'b1; gen_per = 10; gen_high = 5; gen_ph = 0;
    repeat (3) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    waitValid(60, "coinc");
    checkOutput("coinc_phase", phase_cyc, 0);
    checkOutput("coinc_ton", ton_cyc, 5);
    checkOutput("coinc_toff", toff_cyc, 5);
`else
    // 10 MHz, 30 % duty.
    gen_high = 3;
    repeat (20) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    waitValid(60, "duty30");
    checkOutput("duty30_phase", phase_cyc, 0);
    checkOutput("duty30_ton", ton_cyc, 3);
    checkOutput("duty30_toff", toff_cyc, 7);
    checkOutput("duty30_period", period_cyc, 10);
    gen_high = 5;
    repeat (20) applyStimulus(1'b0, 1'b0);
`endif

    // Second start while busy is ignored: exactly one valid.
    applyStimulus(1'b1, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0);
    checkOutput("dbl_busy", busy, 1);
    applyStimulus(1'b1, 1'b0);
`ifdef CLK_MEAS_PHASE_EN
    applyStimulus(1'b0, 1'b1);
`endif
    nvalid = 0;
    for (int i = 0; i < 60; i++) begin
      applyStimulus(1'b0, 1'b0);
      if (valid === 1'b1) nvalid++;
    end
    checkOutput("dbl_valid_count", nvalid, 1);

    // Reset while measuring the high time.
    applyStimulus(1'b1, 1'b0);
`ifdef CLK_MEAS_PHASE_EN
    applyStimulus(1'b0, 1'b1);
`endif
    reached = 1'b0;
    for (int i = 0; i < 40 && !reached; i++) begin
      applyStimulus(1'b0, 1'b0);
      if (active && t_r1 >= 0 && t_f1 < 0) reached = 1'b1;
    end
    checkOutput("rst_reach_high", reached, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_valid", valid, 0);
    checkOutput("rst_ton", ton_cyc, 0);
    checkOutput("rst_toff", toff_cyc, 0);
    checkOutput("rst_period", period_cyc, 0);
    applyStimulus(1'b0, 1'b0);
    rst = 1'b0;
    nvalid = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b0, 1'b0);
      if (valid === 1'b1) nvalid++;
    end
    checkOutput("rst_no_valid", nvalid, 0);

    // Saturation with sig_in held low.
    gen_on = 1'b0;
    repeat (10) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
`ifdef CLK_MEAS_PHASE_EN
    applyStimulus(1'b0, 1'b1);
`endif
    waitValid(400, "sat");
    checkOutput("sat_err", err, 1);
    checkOutput("sat_phase", phase_cyc, PHASE_EN ? MAX : 0);
    checkOutput("sat_ton", ton_cyc, 0);
    checkOutput("sat_toff", toff_cyc, 0);
    repeat (5) applyStimulus(1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
